// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard and a sequential clear sweep.
// Reads are combinational, with optional same-cycle write forwarding; all state updates on Clk.
module reg_file_sb #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    parameter int ADDR_W = $clog2(N_REGS),
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  WR_DATA,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [WIDTH-1:0]  RD_DATA_A,
    output logic [WIDTH-1:0]  RD_DATA_B,
    output logic              RD_BUSY_A,
    output logic              RD_BUSY_B,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    input  logic              CLEAR_START,
    output logic              CLEAR_BUSY
);
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [WIDTH-1:0]  r_mem [N_REGS];
    logic [N_REGS-1:0] r_busy;
    logic              w_idle;
    logic              w_cnt_last;
    logic              w_byp_a;
    logic              w_byp_b;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_cnt_last = (r_cnt == ADDR_W'(N_REGS - 1));
    assign CLEAR_BUSY = (r_state == ST_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (CLEAR_START) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_cnt_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR)
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Issue is assigned after writeback so a same-address collision leaves the bit set.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_REGS; i++)
                r_mem[i] <= '0;
            r_busy <= '0;
        end else if (w_idle) begin
            if (WR_EN) begin
                r_mem[WR_ADDR]  <= WR_DATA;
                r_busy[WR_ADDR] <= 1'b0;
            end
            if (ISSUE_EN)
                r_busy[ISSUE_ADDR] <= 1'b1;
        end else begin
            r_mem[r_cnt]  <= '0;
            r_busy[r_cnt] <= 1'b0;
        end
    end

    assign w_byp_a = (BYPASS != 0) && WR_EN && w_idle && (RD_ADDR_A == WR_ADDR);
    assign w_byp_b = (BYPASS != 0) && WR_EN && w_idle && (RD_ADDR_B == WR_ADDR);

    // Outputs are forced to zero while Reset is held so a pending write cannot leak through.
    always_comb begin
        RD_DATA_A = r_mem[RD_ADDR_A];
        RD_BUSY_A = r_busy[RD_ADDR_A];
        if (Reset) begin
            RD_DATA_A = '0;
            RD_BUSY_A = 1'b0;
        end else if (w_byp_a) begin
            RD_DATA_A = WR_DATA;
            RD_BUSY_A = 1'b0;
        end
    end

    always_comb begin
        RD_DATA_B = r_mem[RD_ADDR_B];
        RD_BUSY_B = r_busy[RD_ADDR_B];
        if (Reset) begin
            RD_DATA_B = '0;
            RD_BUSY_B = 1'b0;
        end else if (w_byp_b) begin
            RD_DATA_B = WR_DATA;
            RD_BUSY_B = 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with write bypass, one without, driven by the same stimulus.
module tb_reg_file_sb;
    logic        Clk = 1'b0;
    logic        Reset, WR_EN, ISSUE_EN, CLEAR_START;
    logic [2:0]  WR_ADDR, RD_ADDR_A, RD_ADDR_B, ISSUE_ADDR;
    logic [15:0] WR_DATA;
    logic [15:0] a_dat, b_dat, nb_a_dat, nb_b_dat;
    logic        a_bsy, b_bsy, clr_bsy, nb_a_bsy, nb_b_bsy, nb_clr;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_mem [8];
    logic [7:0]  m_busy;
    bit          m_track = 1'b0;
    logic [15:0] q_dat [$];
    logic        q_bsy [$];
    logic [15:0] e_dat, e_dat2;
    logic        e_bsy, e_bsy2;

    always #5 Clk = ~Clk;

    reg_file_sb #(.WIDTH(16), .N_REGS(8), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .RD_DATA_A(a_dat), .RD_DATA_B(b_dat),
        .RD_BUSY_A(a_bsy), .RD_BUSY_B(b_bsy), .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR),
        .CLEAR_START(CLEAR_START), .CLEAR_BUSY(clr_bsy)
    );

    reg_file_sb #(.WIDTH(16), .N_REGS(8), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .RD_DATA_A(nb_a_dat), .RD_DATA_B(nb_b_dat),
        .RD_BUSY_A(nb_a_bsy), .RD_BUSY_B(nb_b_bsy), .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR),
        .CLEAR_START(CLEAR_START), .CLEAR_BUSY(nb_clr)
    );

    task automatic idle_inputs();
        WR_EN = 1'b0; ISSUE_EN = 1'b0; CLEAR_START = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_busy = 8'h00;
    endtask

    // One clock: the model commits the driven inputs at the edge, inputs idle at the next negedge.
    task automatic tick();
        @(posedge Clk);
        if (m_track && !Reset) begin
            if (WR_EN) begin
                m_mem[WR_ADDR] = WR_DATA;
                m_busy[WR_ADDR] = 1'b0;
            end
            if (ISSUE_EN) m_busy[ISSUE_ADDR] = 1'b1;
        end
        @(negedge Clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            Reset = 1'b1; WR_EN = 1'b1; WR_ADDR = 3'd2; WR_DATA = 16'hDEAD;
            ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd2; RD_ADDR_A = 3'd2; RD_ADDR_B = 3'd2;
            #1;
            checks++;
            if ({a_dat, b_dat, a_bsy, b_bsy} !== 34'h0) begin
                failures++;
                $display("FAIL reset_held cyc=%0d got a=%h b=%h ba=%b bb=%b exp all zero", c, a_dat, b_dat, a_bsy, b_bsy);
            end
            tick();
        end
        Reset = 1'b0;
        model_zero();
        m_track = 1'b1;
        checks++;
        if (clr_bsy !== 1'b0) begin
            failures++;
            $display("FAIL reset_clear_busy got=%b exp=0", clr_bsy);
        end
        for (int i = 0; i < 8; i++) begin
            RD_ADDR_A = 3'(i); RD_ADDR_B = 3'(7 - i);
            q_dat.push_back(m_mem[i]);     q_bsy.push_back(m_busy[i]);
            q_dat.push_back(m_mem[7 - i]); q_bsy.push_back(m_busy[7 - i]);
            #1;
            e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
            e_dat2 = q_dat.pop_front(); e_bsy2 = q_bsy.pop_front();
            checks++;
            if (a_dat !== e_dat || a_bsy !== e_bsy || b_dat !== e_dat2 || b_bsy !== e_bsy2) begin
                failures++;
                $display("FAIL reset_read i=%0d got a=%h/%b b=%h/%b exp a=%h/%b b=%h/%b",
                         i, a_dat, a_bsy, b_dat, b_bsy, e_dat, e_bsy, e_dat2, e_bsy2);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd3;
        tick();
        WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 16'h1234; RD_ADDR_A = 3'd3;
        q_dat.push_back(WR_DATA);  q_bsy.push_back(1'b0);
        q_dat.push_back(m_mem[3]); q_bsy.push_back(m_busy[3]);
        #1;
        e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
        checks++;
        if (a_dat !== e_dat || a_bsy !== e_bsy) begin
            failures++;
            $display("FAIL bypass_on got=%h/%b exp=%h/%b", a_dat, a_bsy, e_dat, e_bsy);
        end
        e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
        checks++;
        if (nb_a_dat !== e_dat || nb_a_bsy !== e_bsy) begin
            failures++;
            $display("FAIL bypass_off got=%h/%b exp=%h/%b", nb_a_dat, nb_a_bsy, e_dat, e_bsy);
        end
        tick();
        RD_ADDR_A = 3'd3;
        q_dat.push_back(m_mem[3]); q_bsy.push_back(m_busy[3]);
        #1;
        e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
        checks++;
        if (a_dat !== e_dat || nb_a_dat !== e_dat || a_bsy !== e_bsy || nb_a_bsy !== e_bsy) begin
            failures++;
            $display("FAIL bypass_after got=%h/%h busy=%b/%b exp=%h/%b", a_dat, nb_a_dat, a_bsy, nb_a_bsy, e_dat, e_bsy);
        end
        tick();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 8; i++) begin
            WR_EN = 1'b1; WR_ADDR = 3'(i); WR_DATA = 16'hA000 + 16'(i);
            tick();
        end
        RD_ADDR_A = 3'd5; RD_ADDR_B = 3'd2;
        q_dat.push_back(m_mem[5]); q_dat.push_back(m_mem[2]);
        #1;
        e_dat = q_dat.pop_front(); e_dat2 = q_dat.pop_front();
        checks++;
        if (a_dat !== e_dat || b_dat !== e_dat2 || a_dat !== 16'hA005) begin
            failures++;
            $display("FAIL read_r5_r2 got=%h/%h exp=%h/%h", a_dat, b_dat, e_dat, e_dat2);
        end
        tick();
        RD_ADDR_A = 3'd7; RD_ADDR_B = 3'd7;
        q_dat.push_back(m_mem[7]);
        #1;
        e_dat = q_dat.pop_front();
        checks++;
        if (a_dat !== e_dat || b_dat !== e_dat || nb_a_dat !== e_dat || nb_b_dat !== e_dat) begin
            failures++;
            $display("FAIL read_same_r7 got=%h/%h nb=%h/%h exp=%h", a_dat, b_dat, nb_a_dat, nb_b_dat, e_dat);
        end
        tick();
    endtask

    task automatic test_issue();
        ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd4;
        tick();
        for (int c = 0; c < 2; c++) begin
            RD_ADDR_A = 3'd4;
            if (c == 1) begin WR_EN = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'hBEEF; end
            q_bsy.push_back(m_busy[4]);
            q_bsy.push_back(c == 1 ? 1'b0 : m_busy[4]);
            #1;
            e_bsy = q_bsy.pop_front(); e_bsy2 = q_bsy.pop_front();
            checks++;
            if (nb_a_bsy !== e_bsy || a_bsy !== e_bsy2) begin
                failures++;
                $display("FAIL issue_busy cyc=%0d got nb=%b byp=%b exp nb=%b byp=%b", c, nb_a_bsy, a_bsy, e_bsy, e_bsy2);
            end
            tick();
        end
        RD_ADDR_A = 3'd4;
        q_dat.push_back(m_mem[4]); q_bsy.push_back(m_busy[4]);
        #1;
        e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
        checks++;
        if (a_dat !== e_dat || a_bsy !== e_bsy || nb_a_bsy !== e_bsy || e_dat !== 16'hBEEF) begin
            failures++;
            $display("FAIL writeback_clears got=%h/%b nb_busy=%b exp=%h/%b", a_dat, a_bsy, nb_a_bsy, e_dat, e_bsy);
        end
        tick();
        ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd4; WR_EN = 1'b1; WR_ADDR = 3'd4; WR_DATA = 16'h0001;
        tick();
        RD_ADDR_A = 3'd4;
        q_dat.push_back(m_mem[4]); q_bsy.push_back(m_busy[4]);
        #1;
        e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
        checks++;
        if (a_dat !== e_dat || a_bsy !== e_bsy || e_bsy !== 1'b1) begin
            failures++;
            $display("FAIL issue_wins got=%h/%b exp=%h/%b", a_dat, a_bsy, e_dat, e_bsy);
        end
        tick();
        ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd5; WR_EN = 1'b1; WR_ADDR = 3'd6; WR_DATA = 16'h6666;
        tick();
        RD_ADDR_A = 3'd5; RD_ADDR_B = 3'd6;
        q_bsy.push_back(m_busy[5]); q_dat.push_back(m_mem[6]); q_bsy.push_back(m_busy[6]);
        #1;
        e_bsy = q_bsy.pop_front(); e_dat2 = q_dat.pop_front(); e_bsy2 = q_bsy.pop_front();
        checks++;
        if (a_bsy !== e_bsy || b_dat !== e_dat2 || b_bsy !== e_bsy2) begin
            failures++;
            $display("FAIL issue_wr_indep got r5b=%b r6=%h/%b exp r5b=%b r6=%h/%b", a_bsy, b_dat, b_bsy, e_bsy, e_dat2, e_bsy2);
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            RD_ADDR_A = 3'(i); RD_ADDR_B = 3'(i);
            q_dat.push_back(m_mem[i]); q_bsy.push_back(m_busy[i]);
            #1;
            e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
            checks++;
            if (a_dat !== e_dat || a_bsy !== e_bsy || nb_b_dat !== e_dat || nb_b_bsy !== e_bsy) begin
                failures++;
                $display("FAIL %s r%0d got=%h/%b nb=%h/%b exp=%h/%b", tag, i, a_dat, a_bsy, nb_b_dat, nb_b_bsy, e_dat, e_bsy);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        int  highs;
        bit  done;
        for (int i = 0; i < 8; i++) begin
            WR_EN = 1'b1; WR_ADDR = 3'(i); WR_DATA = 16'hFFFF;
            if (i == 7) begin ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd1; end
            tick();
        end
        m_track = 1'b0;
        CLEAR_START = 1'b1;
        tick();
        highs = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (clr_bsy) begin
                // Registers below the sweep index are cleared; the indexed one is not yet.
                RD_ADDR_A = 3'(highs);
                RD_ADDR_B = 3'(highs == 0 ? 0 : highs - 1);
                if (highs == 3) begin WR_EN = 1'b1; WR_ADDR = 3'd1; WR_DATA = 16'h5555; CLEAR_START = 1'b1; end
                if (highs == 5) begin ISSUE_EN = 1'b1; ISSUE_ADDR = 3'd0; end
                if (highs == 6) begin WR_EN = 1'b1; WR_ADDR = 3'd6; WR_DATA = 16'h5555; end
                q_dat.push_back(16'hFFFF); q_bsy.push_back(highs == 1);
                #1;
                e_dat = q_dat.pop_front(); e_bsy = q_bsy.pop_front();
                checks++;
                if (a_dat !== e_dat || a_bsy !== e_bsy || (highs > 0 && (b_dat !== 16'h0 || b_bsy !== 1'b0))) begin
                    failures++;
                    $display("FAIL sweep_partial k=%0d got a=%h/%b b=%h/%b exp a=%h/%b b=0000/0", highs, a_dat, a_bsy, b_dat, b_bsy, e_dat, e_bsy);
                end
                highs++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        if (highs != 8 || !done) begin
            failures++;
            $display("FAIL sweep_length got=%0d exp=8", highs);
        end
        model_zero();
        m_track = 1'b1;
        check_all_zero("after_sweep");
    endtask

    task automatic test_reset_mid_sweep();
        int  highs;
        bit  done;
        WR_EN = 1'b1; WR_ADDR = 3'd5; WR_DATA = 16'h1111;
        tick();
        m_track = 1'b0;
        CLEAR_START = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (clr_bsy !== 1'b1) begin
            failures++;
            $display("FAIL sweep_cycle3_busy got=%b exp=1", clr_bsy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (clr_bsy !== 1'b0 || nb_clr !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got=%b/%b exp=0", clr_bsy, nb_clr);
        end
        model_zero();
        m_track = 1'b1;
        check_all_zero("after_abort");
        m_track = 1'b0;
        CLEAR_START = 1'b1;
        tick();
        highs = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (clr_bsy) begin highs++; tick(); end
            else done = 1'b1;
        end
        checks++;
        if (highs != 8 || !done) begin
            failures++;
            $display("FAIL resweep_length got=%0d exp=8", highs);
        end
        m_track = 1'b1;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        WR_ADDR = '0; WR_DATA = '0; RD_ADDR_A = '0; RD_ADDR_B = '0; ISSUE_ADDR = '0;
        @(negedge Clk);
        test_reset();
        test_bypass();
        test_write_read();
        test_issue();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the LC-3 datapath and its successors. Width, depth and write-bypass are configurable.
- Adds a per-register busy scoreboard: issue marks a destination busy, writeback clears it.
- Adds a sequential clear sweep that zeroes the whole file without asserting Reset.
- Sits between the bus/ALU writeback and the SR1/SR2 operand path. The control FSM polls the busy flags before reading operands.

Parameters:
- WIDTH, 16, data width of each register.
- N_REGS, 8, number of registers; must be a power of two and at least 2.
- ADDR_W, $clog2(N_REGS), register address width (derived; do not override).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- WR_EN  in  1  writeback enable (LD).
- WR_ADDR  in  ADDR_W  writeback destination (DR).
- WR_DATA  in  WIDTH  writeback data (bus result).
- RD_ADDR_A  in  ADDR_W  read port A address (SR1).
- RD_ADDR_B  in  ADDR_W  read port B address (SR2).
- RD_DATA_A  out  WIDTH  read port A data.
- RD_DATA_B  out  WIDTH  read port B data.
- RD_BUSY_A  out  1  busy flag of the register addressed by port A.
- RD_BUSY_B  out  1  busy flag of the register addressed by port B.
- ISSUE_EN  in  1  mark register ISSUE_ADDR busy.
- ISSUE_ADDR  in  ADDR_W  register to mark busy.
- CLEAR_START  in  1  one-cycle pulse that starts the clear sweep.
- CLEAR_BUSY  out  1  high while the sweep runs.

Behaviour:
- Reset (Clk is the only clock; Reset is synchronous, active-high):
  - All registers are 0 and all busy bits are 0.
  - FSM goes to IDLE, sweep counter is 0, CLEAR_BUSY is 0.
  - With Reset held, RD_DATA_* are 0 and RD_BUSY_* are 0.
  - Reset mid-sweep aborts the sweep and applies the above.
- Reads:
  - Combinational from the addressed register; zero-cycle latency.
  - Both ports may address the same register.
- Write:
  - WR_EN=1 in IDLE: reg[WR_ADDR] <= WR_DATA at the edge; busy[WR_ADDR] is cleared.
- Bypass, BYPASS=1:
  - Applies when WR_EN=1, the FSM is in IDLE and RD_ADDR_x == WR_ADDR.
  - RD_DATA_x = WR_DATA in the same cycle and RD_BUSY_x = 0.
- Bypass, BYPASS=0:
  - Reads return the old value until the edge after the write.
  - RD_BUSY_x reflects the stored busy bit only.
- Issue:
  - ISSUE_EN=1 in IDLE sets busy[ISSUE_ADDR] at the edge.
  - If issue and writeback hit the same address in the same cycle, set wins: the bit ends at 1 and the data is still written.
  - Issue and writeback to different addresses update independently.
- FSM states:
  - IDLE -> CLEAR on CLEAR_START=1.
  - CLEAR: each cycle writes 0 to reg[cnt], clears busy[cnt], then cnt++.
  - CLEAR -> IDLE on the edge that processes cnt == N_REGS-1; cnt returns to 0.
  - The sweep takes exactly N_REGS cycles.
  - CLEAR_BUSY = (state == CLEAR); it is registered and rises on the edge after CLEAR_START.
- During CLEAR:
  - WR_EN, ISSUE_EN and CLEAR_START are ignored.
  - No bypass; reads return the current stored contents (partially cleared).
- CLEAR_START while already in CLEAR does not restart the sweep.
- Arithmetic: cnt is ADDR_W bits wide. The terminal compare is against N_REGS-1, so there is no wrap and no extra cycle.

Test Plan:
- Reset held for 2 cycles, then released -> RD_DATA_A/B = 0x0000 at every address; RD_BUSY_A/B = 0; CLEAR_BUSY = 0.
- Write 0x1234 to R3 with RD_ADDR_A=3 in the same cycle, BYPASS=1 -> RD_DATA_A=0x1234 that cycle. With BYPASS=0 -> old value 0x0000 that cycle, 0x1234 from the next cycle.
- Write R0..R7 with 0xA000+i, then read R5 on port A and R2 on port B -> 0xA005 and 0xA002. Both ports on R7 -> 0xA007 on both.
- ISSUE R4, then WR_EN R4=0xBEEF two cycles later -> RD_BUSY(4)=1 for those two cycles, 0 after the write edge, data 0xBEEF. Simultaneous ISSUE R4 and WR R4=0x0001 -> busy stays 1, data 0x0001.
- Load all registers with 0xFFFF and mark R1 busy, then pulse CLEAR_START -> CLEAR_BUSY high for exactly 8 cycles. A WR_EN R6=0x5555 issued mid-sweep is ignored. After the sweep, all registers read 0 and all busy bits are 0.
- Assert Reset at sweep cycle 3 -> next cycle CLEAR_BUSY=0 and all registers 0. A new CLEAR_START afterwards runs a full 8-cycle sweep.
